// File: rtl/timer_arbiter.sv
// timer_arbiter: one countdown timer shared round-robin between N_REQ requesters.
//   An idle timer grants the first requester found searching upward from the
//   round-robin pointer, loads that requester's tick count and counts down on
//   clk_en. When the count expires, the owner gets a one-hot done strobe for
//   one enabled period. The pointer then moves past the owner.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   clk_en      tick enable; every state/counter update is gated by it
//   req         level request per requester, held until its done
//   req_ticks   per-requester duration, slice i = [i*CNT_W +: CNT_W]
//   grant       one-hot timer owner, 0 when idle
//   done        one-hot completion strobe to the owner
//   busy        timer owned (COUNT or DONE)
//   remaining   current counter value, 0 when idle
// Optional feature macro TIMER_ARBITER_ABORT_EN:
//   If the owner drops req during COUNT, the timer returns straight to IDLE.
//   No done strobe is issued, and the pointer advances past the owner.
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_ticks,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       remaining
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_d;
  logic [PTR_W-1:0]  rr_ptr, rr_d;
  logic [PTR_W-1:0]  owner, owner_d, owner_nxt;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [N_REQ-1:0]  grant_d, done_d;
  logic [CNT_W-1:0]  ticks [N_REQ];
  logic              pick_vld;
  logic [PTR_W-1:0]  pick_idx;
  logic              abort;

  for (genvar i = 0; i < N_REQ; i++) begin : g_ticks
    assign ticks[i] = req_ticks[i*CNT_W +: CNT_W];
  end

  // Rotating priority search. The loop walks from lowest to highest priority,
  // so the last hit, which is the one closest to rr_ptr, wins.
  always_comb begin
    int s;
    s        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      s = int'(rr_ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (req[PTR_W'(s)]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(s);
      end
    end
  end

  assign owner_nxt = (owner == PTR_W'(N_REQ-1)) ? '0 : owner + 1'b1;

`ifdef TIMER_ARBITER_ABORT_EN
  assign abort = ~req[owner];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    grant_d = grant;
    done_d  = done;
    rr_d    = rr_ptr;
    owner_d = owner;
    if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            state_d           = COUNT;
            owner_d           = pick_idx;
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            // A zero duration still takes one tick so done always follows a grant.
            cnt_d             = (ticks[pick_idx] == '0) ? CNT_W'(1) : ticks[pick_idx];
          end
        end
        COUNT: begin
          if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            grant_d = '0;
            rr_d    = owner_nxt;
          end else if (cnt <= CNT_W'(1)) begin
            state_d = DONE;
            cnt_d   = '0;
            done_d  = grant;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = '0;
          rr_d    = owner_nxt;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
          done_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      grant  <= '0;
      done   <= '0;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      grant  <= grant_d;
      done   <= done_d;
      rr_ptr <= rr_d;
      owner  <= owner_d;
    end
  end

  assign busy      = (state != IDLE);
  assign remaining = cnt;

  a_grant_oh: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_done_oh:  assert property (@(posedge clk) disable iff (reset) $onehot0(done));
  a_done_own: assert property (@(posedge clk) disable iff (reset) (|done) |-> (done == grant));

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 16;
`ifdef TIMER_ARBITER_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         clk_en;
  logic [N-1:0] req;
  logic [N*W-1:0] req_ticks;
  logic [N-1:0] grant, done;
  logic         busy;
  logic [W-1:0] remaining;
  logic [W-1:0] tk [N];

  int total = 0;
  int bad   = 0;

  // reference model: who owns the timer, ticks left, done phase, rr pointer
  int m_owner;
  int m_left;
  int m_rr;
  bit m_done;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_ticks[g*W +: W] = tk[g];
  end

  timer_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .req(req), .req_ticks(req_ticks),
    .grant(grant), .done(done), .busy(busy), .remaining(remaining)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    m_owner = -1; m_left = 0; m_rr = 0; m_done = 1'b0;
  endfunction

  function automatic void model_edge();
    if (!clk_en) return;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_rr + k) % N;
        if (m_owner < 0 && req[i]) begin
          m_owner = i;
          m_left  = (tk[i] == 0) ? 1 : int'(tk[i]);
        end
      end
    end else if (m_done) begin
      m_rr = (m_owner + 1) % N; m_owner = -1; m_done = 1'b0;
    end else if (ABORT && !req[m_owner]) begin
      m_rr = (m_owner + 1) % N; m_owner = -1; m_left = 0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1'b1;
    end
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [N-1:0] exp_done();
    return m_done ? exp_grant() : '0;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = '0; clk_en = 1'b1;
    for (int i = 0; i < N; i++) tk[i] = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; req = 4'b1111;
    for (int i = 0; i < N; i++) tk[i] = 16'd5;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({grant, done, busy, remaining} !== '0) begin
      bad++;
      $display("FAIL reset_hold grant=%b done=%b busy=%b rem=%0d want all zero", grant, done, busy, remaining);
    end
    req = '0;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if ({grant, done, busy, remaining} !== {exp_grant(), exp_done(), m_owner >= 0, W'(m_left)}
          || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_noreq c%0d grant=%b done=%b busy=%b rem=%0d want idle", c, grant, done, busy, remaining);
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] tg [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [N-1:0] td [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    int           tr [5] = '{3, 2, 1, 0, 0};
    apply_reset();
    tk[2] = 16'd3; req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (grant !== tg[c] || done !== td[c] || remaining !== W'(tr[c])) begin
        bad++;
        $display("FAIL single c%0d grant=%b done=%b rem=%0d want %b %b %0d",
                 c, grant, done, remaining, tg[c], td[c], tr[c]);
      end
      if (c == 3) req = '0;
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seen [$];
    logic [N-1:0] want [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    logic [N-1:0] prev;
    apply_reset();
    for (int i = 0; i < N; i++) tk[i] = 16'd1;
    req = 4'b1011;
    prev = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      total++;
      if ({grant, done, busy, remaining} !== {exp_grant(), exp_done(), m_owner >= 0, W'(m_left)}) begin
        bad++;
        $display("FAIL rr_model c%0d grant=%b done=%b rem=%0d want %b %b %0d",
                 c, grant, done, remaining, exp_grant(), exp_done(), m_left);
      end
      if (grant != '0 && prev == '0) seen.push_back(grant);
      prev = grant;
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= seen.size() || seen[k] !== want[k]) begin
        bad++;
        $display("FAIL rr_order k%0d got=%b want=%b", k, (k < seen.size()) ? seen[k] : 4'bxxxx, want[k]);
      end
    end
  endtask

  task automatic test_zero_slow_en();
    int n_done, n_grant, n_rem1;
    apply_reset();
    tk[0] = 16'd0; req = 4'b0001;
    n_done = 0; n_grant = 0; n_rem1 = 0;
    for (int c = 0; c < 12; c++) begin
      clk_en = (c % 3 == 0);
      step();
      total++;
      if ({grant, done, busy, remaining} !== {exp_grant(), exp_done(), m_owner >= 0, W'(m_left)}) begin
        bad++;
        $display("FAIL slow_en c%0d grant=%b done=%b rem=%0d want %b %b %0d",
                 c, grant, done, remaining, exp_grant(), exp_done(), m_left);
      end
      if (done == 4'b0001) begin n_done++; req = '0; end
      if (grant == 4'b0001) n_grant++;
      if (remaining == 16'd1) n_rem1++;
    end
    total++;
    if (n_done != 3 || n_grant != 6 || n_rem1 != 3) begin
      bad++;
      $display("FAIL slow_en_len done=%0d grant=%0d rem1=%0d want 3 6 3", n_done, n_grant, n_rem1);
    end
    clk_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int guard;
    apply_reset();
    tk[0] = 16'd2; req = 4'b0001;
    guard = 0;
    while (guard < 10) begin
      step();
      if (done != '0) req = '0;
      if (!busy && req == '0) break;
      guard++;
    end
    tk[1] = 16'd8; req = 4'b0011;
    step();
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL midrst_pre grant=%b want 0010", grant);
    end
    guard = 0;
    while (remaining != 16'd5 && guard < 20) begin step(); guard++; end
    total++;
    if (remaining !== 16'd5) begin
      bad++;
      $display("FAIL midrst_wait rem=%0d want 5", remaining);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({grant, done, busy, remaining} !== '0) begin
      bad++;
      $display("FAIL midrst_zero grant=%b done=%b busy=%b rem=%0d want all zero", grant, done, busy, remaining);
    end
    model_reset();
    #2 reset = 1'b0;
    step();
    total++;
    if (grant !== 4'b0001 || done !== '0) begin
      bad++;
      $display("FAIL midrst_ptr grant=%b done=%b want 0001 0000", grant, done);
    end
  endtask

  task automatic test_drop_req();
    int guard, n_done;
    apply_reset();
    tk[1] = 16'd6; req = 4'b0010;
    guard = 0;
    while (remaining != 16'd4 && guard < 20) begin step(); guard++; end
    total++;
    if (remaining !== 16'd4) begin
      bad++;
      $display("FAIL drop_wait rem=%0d want 4", remaining);
    end
    req = '0;
    step();
    total++;
    if (busy !== !ABORT || remaining !== (ABORT ? 16'd0 : 16'd3)) begin
      bad++;
      $display("FAIL drop_first busy=%b rem=%0d want %b %0d", busy, remaining, !ABORT, ABORT ? 0 : 3);
    end
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if ({grant, done, busy, remaining} !== {exp_grant(), exp_done(), m_owner >= 0, W'(m_left)}) begin
        bad++;
        $display("FAIL drop_model c%0d grant=%b done=%b rem=%0d want %b %b %0d",
                 c, grant, done, remaining, exp_grant(), exp_done(), m_left);
      end
      if (done == 4'b0010) n_done++;
    end
    total++;
    if (n_done != (ABORT ? 0 : 1)) begin
      bad++;
      $display("FAIL drop_done count=%0d want %0d", n_done, ABORT ? 0 : 1);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ed;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        if ($urandom_range(0, 2) == 0) tk[i] = W'($urandom_range(0, 5));
      end
      step();
      total++;
      if ({grant, done, busy, remaining} !== {exp_grant(), exp_done(), m_owner >= 0, W'(m_left)}) begin
        bad++;
        $display("FAIL random c%0d grant=%b done=%b busy=%b rem=%0d want %b %b %b %0d",
                 c, grant, done, busy, remaining, exp_grant(), exp_done(), m_owner >= 0, m_left);
      end
      ed = exp_done();
      for (int i = 0; i < N; i++)
        if (ed[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; req = '0;
    for (int i = 0; i < N; i++) tk[i] = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_zero_slow_en();
    test_reset_mid();
    test_drop_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
